matrix_op_sequencer: RTL and testbench
======================================

Name: matrix_op_sequencer

Overview:
- Controller that sequences one matrix operation end to end.
- Reads a header word, operand A and operand B from the single-port 256-bit RAM, launches the matrix arithmetic unit through a start/done handshake, then writes the result back to RAM.
- Sits between the host/switch logic and the RAM + matrix unit, replacing the ad-hoc count-driven sequencing in the top level.
- Adds size validation, an execution timeout and busy/done/error status.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 256, RAM word and matrix bus width.
- RD_LAT, 2, RAM read latency in clocks from address change to valid ram_rdata (legal values 1..7).
- TIMEOUT, 1024, maximum clocks spent waiting for op_done before the error path is taken.

Ports:
- clk  in  1  system clock; all logic is clocked on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request a new operation; sampled only in IDLE and ERR.
- base_addr  in  ADDR_W  address of the header word; latched when start is accepted.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result write has completed.
- error  out  1  sticky flag: invalid header or timeout.
- ram_addr  out  ADDR_W  RAM address.
- ram_wren  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- op_size  out  3  matrix dimension, taken from header bits [2:0].
- op_code  out  3  operation select, taken from header bits [5:3].
- op_a  out  DATA_W  operand A.
- op_b  out  DATA_W  operand B.
- op_start  out  1  one-cycle launch pulse to the matrix unit.
- op_done  in  1  completion strobe from the matrix unit.
- op_result  in  DATA_W  result from the matrix unit; valid while op_done is high.

Behaviour:
- Reset (asynchronous, rst=0):
  - State goes to IDLE.
  - busy, done, error, ram_wren and op_start are 0.
  - ram_addr, ram_wdata, op_size, op_code, op_a and op_b are 0.
  - Reset mid-operation aborts immediately; no RAM write occurs after rst is asserted.
- States: IDLE, RD_HDR, RD_A, RD_B, EXEC, WR, DONE, ERR.
- IDLE:
  - On an edge with start=1: latch base_addr, set ram_addr<=base, busy<=1, wait counter<=0, go to RD_HDR.
- Read states (RD_HDR, RD_A, RD_B):
  - The counter increments each edge.
  - On the edge where the counter equals RD_LAT, ram_rdata is captured, the counter clears, and ram_addr advances.
  - Each read state therefore lasts RD_LAT+1 cycles.
- RD_HDR capture:
  - Load op_size=hdr[2:0] and op_code=hdr[5:3].
  - Valid header: size in 2..5 and op_code in 0..3. Go to RD_A with ram_addr<=base+1.
  - Invalid header: go to ERR.
- RD_A capture: load op_a, set ram_addr<=base+2, go to RD_B.
- RD_B capture: load op_b, set op_start<=1 for exactly one cycle, clear the counter, go to EXEC.
- EXEC:
  - On an edge with op_done=1: ram_wdata<=op_result, ram_addr<=base+3, ram_wren<=1, go to WR.
  - If op_done is still absent when the counter reaches TIMEOUT-1, go to ERR.
- WR: single write cycle, then ram_wren<=0, done<=1, busy<=0, go to DONE.
- DONE: done<=0, go to IDLE. done is a single-cycle pulse.
- ERR:
  - On entry: error<=1, busy<=0, ram_wren=0.
  - The state holds until start=1. That start clears error and begins a new operation exactly as from IDLE.
- Latency:
  - done rises 3·(RD_LAT+1)+k+2 edges after the start edge, where k is the number of edges in EXEC up to and including the op_done edge (k≥1).
  - With RD_LAT=2 and op_done on the first EXEC edge, done rises on edge 12.
- Address arithmetic: base+1, base+2 and base+3 are computed modulo 2^ADDR_W (base=8'hFE gives 8'hFF, 8'h00, 8'h01).
- Ignored inputs:
  - start is ignored while busy.
  - op_done is ignored outside EXEC.
  - op_done and the timeout occurring on the same edge: op_done wins.
- Operand outputs: op_a, op_b, op_size and op_code hold their last captured values until overwritten by the next operation.

Decomposition:
- Shared package matrix_ctrl_pkg:
  - state enum;
  - header field positions (SIZE_LSB=0, OP_LSB=3);
  - SIZE_MIN=2 and SIZE_MAX=5;
  - address offsets OFF_A=1, OFF_B=2, OFF_C=3;
  - op_code constants.
- Sub-module mseq_wait_timer:
  - a loadable counter with a terminal-count compare;
  - one instance serves both the RD_LAT wait and the TIMEOUT wait.

Test Plan:
- Nominal run, RD_LAT=2, base=8'h10, header=8'h03, matrix-unit model asserts op_done 4 cycles after op_start → reads at addresses 10/11/12, op_a/op_b equal the RAM contents, a single wren cycle at addr 8'h13 with data = result, done pulses once on edge 15, busy clears on that same edge.
- Invalid header, size=7 → ERR after 3 cycles, error=1, op_start never asserted, no write; a following start with a valid header clears error and completes normally.
- Timeout, TIMEOUT=16, op_done never asserted → error=1 exactly 16 cycles after entering EXEC, ram_wren stays 0.
- Wrap, base=8'hFE → read addresses FE, FF, 00; result written to 01.
- start pulsed while busy, and op_done pulsed while in IDLE → no effect; exactly one done per accepted start.
- rst asserted in EXEC → all outputs return to reset values asynchronously, no write; after release the state is IDLE and a new start runs normally.

Source files
------------

// File: rtl/matrix_op_sequencer_pkg.sv
// Shared types and constants for the matrix operation sequencer:
// state encoding, header field layout, operand offsets and op codes.
package matrix_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_HDR,
    ST_RD_A,
    ST_RD_B,
    ST_EXEC,
    ST_WR,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int SIZE_LSB = 0;
  localparam int OP_LSB   = 3;
  localparam int FIELD_W  = 3;

  localparam logic [FIELD_W-1:0] SIZE_MIN = 3'd2;
  localparam logic [FIELD_W-1:0] SIZE_MAX = 3'd5;

  localparam int OFF_A = 1;
  localparam int OFF_B = 2;
  localparam int OFF_C = 3;

  localparam logic [FIELD_W-1:0] OP_ADD       = 3'd0;
  localparam logic [FIELD_W-1:0] OP_SUB       = 3'd1;
  localparam logic [FIELD_W-1:0] OP_MUL       = 3'd2;
  localparam logic [FIELD_W-1:0] OP_TRANSPOSE = 3'd3;

  // Codes above OP_TRANSPOSE are reserved and rejected.
  function automatic logic hdr_valid(input logic [FIELD_W-1:0] size,
                                     input logic [FIELD_W-1:0] code);
    return (size >= SIZE_MIN) && (size <= SIZE_MAX) && (code <= OP_TRANSPOSE);
  endfunction

endpackage

// File: rtl/matrix_op_sequencer_if.sv
// RAM and matrix-unit bus driven by the sequencer (master) and served by
// the memory / arithmetic side (slave).
interface matrix_op_sequencer_if
  import matrix_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 256
);

  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_wren;
  logic [DATA_W-1:0]  ram_wdata;
  logic [DATA_W-1:0]  ram_rdata;
  logic [FIELD_W-1:0] op_size;
  logic [FIELD_W-1:0] op_code;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic               op_start;
  logic               op_done;
  logic [DATA_W-1:0]  op_result;

  modport master (
    output ram_addr, ram_wren, ram_wdata, op_size, op_code, op_a, op_b, op_start,
    input  ram_rdata, op_done, op_result
  );

  modport slave (
    input  ram_addr, ram_wren, ram_wdata, op_size, op_code, op_a, op_b, op_start,
    output ram_rdata, op_done, op_result
  );

endinterface

// File: rtl/matrix_op_sequencer_wait_timer.sv
// Clearable up-counter with a terminal-count compare; shared between the
// RAM read-latency wait and the execution timeout.
module mseq_wait_timer #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/matrix_op_sequencer.sv
// Sequences one matrix operation: header/A/B reads, matrix-unit launch,
// result write-back, with header validation and an execution timeout.
module matrix_op_sequencer
  import matrix_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 256,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  matrix_op_sequencer_if.master bus
);

  localparam int TW = ($clog2(TIMEOUT) > 3) ? $clog2(TIMEOUT) : 3;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               wren_q, wren_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [FIELD_W-1:0] size_q, size_d;
  logic [FIELD_W-1:0] code_q, code_d;
  logic [DATA_W-1:0]  opa_q, opa_d;
  logic [DATA_W-1:0]  opb_q, opb_d;
  logic               opstart_q, opstart_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               tmr_clr, tmr_en, tmr_tc;
  logic [TW-1:0]      tmr_val;
  logic [FIELD_W-1:0] hdr_size, hdr_code;

  assign hdr_size = bus.ram_rdata[SIZE_LSB +: FIELD_W];
  assign hdr_code = bus.ram_rdata[OP_LSB +: FIELD_W];

  // The timer waits RD_LAT in the read states and TIMEOUT-1 while executing.
  assign tmr_val = (state_q == ST_EXEC) ? TW'(TIMEOUT - 1) : TW'(RD_LAT);

  mseq_wait_timer #(.W(TW)) u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .tc_val_i(tmr_val),
    .tc_o    (tmr_tc)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    code_d    = code_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    busy_d    = busy_q;
    error_d   = error_q;
    wren_d    = 1'b0;
    opstart_d = 1'b0;
    done_d    = 1'b0;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start_i) begin
          base_d  = base_addr_i;
          addr_d  = base_addr_i;
          busy_d  = 1'b1;
          error_d = 1'b0;
          tmr_clr = 1'b1;
          state_d = ST_RD_HDR;
        end
      end
      ST_RD_HDR: begin
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          size_d  = hdr_size;
          code_d  = hdr_code;
          if (hdr_valid(hdr_size, hdr_code)) begin
            addr_d  = base_q + ADDR_W'(OFF_A);
            state_d = ST_RD_A;
          end else begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_ERR;
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_RD_A: begin
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          opa_d   = bus.ram_rdata;
          addr_d  = base_q + ADDR_W'(OFF_B);
          state_d = ST_RD_B;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_RD_B: begin
        if (tmr_tc) begin
          tmr_clr   = 1'b1;
          opb_d     = bus.ram_rdata;
          opstart_d = 1'b1;
          state_d   = ST_EXEC;
        end else begin
          tmr_en = 1'b1;
        end
      end
      // op_done is checked before the timeout so a late completion still wins.
      ST_EXEC: begin
        if (bus.op_done) begin
          wdata_d = bus.op_result;
          addr_d  = base_q + ADDR_W'(OFF_C);
          wren_d  = 1'b1;
          state_d = ST_WR;
        end else if (tmr_tc) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_ERR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WR: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      addr_q    <= '0;
      wren_q    <= 1'b0;
      wdata_q   <= '0;
      size_q    <= '0;
      code_q    <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      opstart_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      wren_q    <= wren_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      code_q    <= code_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      opstart_q <= opstart_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wren  = wren_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.op_size   = size_q;
  assign bus.op_code   = code_q;
  assign bus.op_a      = opa_q;
  assign bus.op_b      = opb_q;
  assign bus.op_start  = opstart_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Self-checking bench for matrix_op_sequencer: RAM and matrix-unit models,
// per-operation event logs and expectations derived from the operation rules.
module tb_matrix_op_sequencer;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 256;
  localparam int RD_LAT  = 2;
  localparam int TIMEOUT = 16;
  localparam int WIN     = 40;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] baseAddr = '0;
  logic              busy, done, error;

  int vectors = 0;
  int miscompares = 0;

  matrix_op_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  matrix_op_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .base_addr_i(baseAddr),
    .busy_o     (busy),
    .done_o     (done),
    .error_o    (error),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // RAM: data appears RD_LAT (=2) clocks after the address changes.
  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] pipe1 = '0, rdataQ = '0;
  always @(posedge clk) begin
    pipe1  <= mem[bus.ram_addr];
    rdataQ <= pipe1;
  end
  assign bus.ram_rdata = rdataQ;

  // Matrix unit: raises op_done so the DUT sees it on the kTarget-th EXEC edge.
  int                kTarget = 0;
  int                execN = 0;
  logic              mdlDone = 1'b0;
  logic              strayDone = 1'b0;
  logic [DATA_W-1:0] mdlResult = '0;
  always @(posedge clk) begin
    #1;
    if (bus.op_start) execN = 1;
    else if (execN > 0) execN++;
    mdlDone = (kTarget > 0) && (execN == kTarget);
  end
  assign bus.op_done   = mdlDone | strayDone;
  assign bus.op_result = mdlDone ? mdlResult : ~mdlResult;

  // Per-edge log of one operation window; index 1 is the start edge.
  logic [ADDR_W-1:0] lgAddr  [0:WIN];
  logic [DATA_W-1:0] lgWdata [0:WIN];
  logic              lgWren  [0:WIN];
  logic              lgDone  [0:WIN];
  logic              lgBusy  [0:WIN];
  logic              lgErr   [0:WIN];
  logic              lgStart [0:WIN];

  int                firstDone, doneCnt, wrenCnt, firstWren, startCnt, firstStart, firstErr;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;

  function automatic logic [DATA_W-1:0] rand256();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference timing, counted in edges with the accepted start edge as 1.
  function automatic int expDoneEdge(input int k);
    return 3 * (RD_LAT + 1) + k + 2;
  endfunction

  function automatic int expHdrErrEdge();
    return (RD_LAT + 1) + 1;
  endfunction

  function automatic int expTimeoutEdge();
    return 3 * (RD_LAT + 1) + 1 + TIMEOUT;
  endfunction

  function automatic logic refValid(input logic [2:0] size, input logic [2:0] code);
    return (size >= 3'd2) && (size <= 3'd5) && (code <= 3'd3);
  endfunction

  task automatic scanLog();
    firstDone = 0; doneCnt = 0; wrenCnt = 0; firstWren = 0;
    startCnt = 0; firstStart = 0; firstErr = 0;
    wrAddr = '0; wrData = '0;
    for (int n = 1; n <= WIN; n++) begin
      if (lgDone[n]) begin
        doneCnt++;
        if (firstDone == 0) firstDone = n;
      end
      if (lgWren[n]) begin
        wrenCnt++;
        if (firstWren == 0) begin
          firstWren = n;
          wrAddr = lgAddr[n];
          wrData = lgWdata[n];
        end
      end
      if (lgStart[n]) begin
        startCnt++;
        if (firstStart == 0) firstStart = n;
      end
      if (lgErr[n] && firstErr == 0) firstErr = n;
    end
  endtask

  task automatic applyOp(input logic [ADDR_W-1:0] base, input logic [DATA_W-1:0] hdrW,
                         input logic [DATA_W-1:0] aW, input logic [DATA_W-1:0] bW,
                         input logic [DATA_W-1:0] resW, input int k,
                         input int strayStartAt, input int strayDoneAt);
    logic [ADDR_W-1:0] ia, ib;
    ia = base + 8'd1;
    ib = base + 8'd2;
    @(negedge clk);
    mem[base] = hdrW;
    mem[ia]   = aW;
    mem[ib]   = bW;
    kTarget   = k;
    mdlResult = resW;
    start     = 1'b1;
    baseAddr  = base;
    for (int n = 1; n <= WIN; n++) begin
      @(posedge clk);
      #1;
      lgAddr[n]  = bus.ram_addr;
      lgWdata[n] = bus.ram_wdata;
      lgWren[n]  = bus.ram_wren;
      lgDone[n]  = done;
      lgBusy[n]  = busy;
      lgErr[n]   = error;
      lgStart[n] = bus.op_start;
      start      = (n + 1 == strayStartAt);
      if (start) baseAddr = 8'($urandom);
      strayDone  = (n + 1 == strayDoneAt);
    end
    start = 1'b0;
    strayDone = 1'b0;
    scanLog();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if ({busy, done, error, bus.ram_wren, bus.op_start} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got %b expected 00000",
               {busy, done, error, bus.ram_wren, bus.op_start});
    end
    vectors++;
    if ({bus.ram_addr, bus.op_size, bus.op_code} !== 14'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_addr_fields: got %h expected 0",
               {bus.ram_addr, bus.op_size, bus.op_code});
    end
    vectors++;
    if ((bus.ram_wdata | bus.op_a | bus.op_b) !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h expected 0", bus.ram_wdata | bus.op_a | bus.op_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    logic [DATA_W-1:0] hdrW, aW, bW, resW;
    hdrW = rand256(); hdrW[5:0] = 6'h03;
    aW = rand256(); bW = rand256(); resW = rand256();
    applyOp(8'h10, hdrW, aW, bW, resW, 4, 0, 0);
    vectors++;
    if (firstDone !== expDoneEdge(4)) begin
      miscompares++;
      $display("[TB] FAIL nominal_done_edge: got %0d expected %0d", firstDone, expDoneEdge(4));
    end
    vectors++;
    if (doneCnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL nominal_done_count: got %0d expected 1", doneCnt);
    end
    vectors++;
    if ({lgBusy[14], lgBusy[15]} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL nominal_busy_clear: got %b expected 10", {lgBusy[14], lgBusy[15]});
    end
    vectors++;
    if (wrenCnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL nominal_wren_count: got %0d expected 1", wrenCnt);
    end
    vectors++;
    if (wrAddr !== 8'h13) begin
      miscompares++;
      $display("[TB] FAIL nominal_wr_addr: got %h expected 13", wrAddr);
    end
    vectors++;
    if (wrData !== resW) begin
      miscompares++;
      $display("[TB] FAIL nominal_wr_data: got %h expected %h", wrData, resW);
    end
    vectors++;
    if (bus.op_a !== aW || bus.op_b !== bW) begin
      miscompares++;
      $display("[TB] FAIL nominal_operands: got a=%h b=%h", bus.op_a, bus.op_b);
    end
    vectors++;
    if ({bus.op_size, bus.op_code} !== {3'd3, 3'd0}) begin
      miscompares++;
      $display("[TB] FAIL nominal_hdr_fields: got %h expected 18", {bus.op_size, bus.op_code});
    end
    vectors++;
    if ({lgAddr[1], lgAddr[4], lgAddr[7]} !== 24'h101112) begin
      miscompares++;
      $display("[TB] FAIL nominal_read_addrs: got %h expected 101112",
               {lgAddr[1], lgAddr[4], lgAddr[7]});
    end
    vectors++;
    if (startCnt !== 1 || firstStart !== 3 * (RD_LAT + 1) + 1) begin
      miscompares++;
      $display("[TB] FAIL nominal_op_start: got count %0d edge %0d expected count 1 edge %0d",
               startCnt, firstStart, 3 * (RD_LAT + 1) + 1);
    end
  endtask

  task automatic test_invalid_header();
    logic [DATA_W-1:0] hdrW, resW;
    hdrW = rand256(); hdrW[5:0] = 6'h07;
    applyOp(8'h20, hdrW, rand256(), rand256(), rand256(), 4, 0, 0);
    vectors++;
    if (firstErr !== expHdrErrEdge()) begin
      miscompares++;
      $display("[TB] FAIL invalid_err_edge: got %0d expected %0d", firstErr, expHdrErrEdge());
    end
    vectors++;
    if ({startCnt, wrenCnt, doneCnt} !== {32'd0, 32'd0, 32'd0}) begin
      miscompares++;
      $display("[TB] FAIL invalid_no_activity: got start %0d wren %0d done %0d expected 0 0 0",
               startCnt, wrenCnt, doneCnt);
    end
    vectors++;
    if (lgBusy[expHdrErrEdge()] !== 1'b0 || lgErr[WIN] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL invalid_status: got busy %b error %b expected 0 1",
               lgBusy[expHdrErrEdge()], lgErr[WIN]);
    end
    hdrW[5:0] = {3'd3, 3'd5};
    resW = rand256();
    applyOp(8'h40, hdrW, rand256(), rand256(), resW, 1, 0, 0);
    vectors++;
    if (lgErr[1] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL recover_err_clear: got %b expected 0", lgErr[1]);
    end
    vectors++;
    if (firstDone !== expDoneEdge(1) || wrAddr !== 8'h43 || wrData !== resW) begin
      miscompares++;
      $display("[TB] FAIL recover_op: got done %0d addr %h expected done %0d addr 43",
               firstDone, wrAddr, expDoneEdge(1));
    end
  endtask

  task automatic test_timeout();
    logic [DATA_W-1:0] hdrW;
    hdrW = rand256(); hdrW[5:0] = {3'd2, 3'd2};
    applyOp(8'h60, hdrW, rand256(), rand256(), rand256(), 0, 0, 0);
    vectors++;
    if (firstErr !== expTimeoutEdge()) begin
      miscompares++;
      $display("[TB] FAIL timeout_err_edge: got %0d expected %0d", firstErr, expTimeoutEdge());
    end
    vectors++;
    if (wrenCnt !== 0 || doneCnt !== 0) begin
      miscompares++;
      $display("[TB] FAIL timeout_no_write: got wren %0d done %0d expected 0 0", wrenCnt, doneCnt);
    end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] hdrW, aW, bW, resW;
    hdrW = rand256(); hdrW[5:0] = {3'd1, 3'd4};
    aW = rand256(); bW = rand256(); resW = rand256();
    applyOp(8'hFE, hdrW, aW, bW, resW, 3, 0, 0);
    vectors++;
    if ({lgAddr[1], lgAddr[4], lgAddr[7]} !== 24'hFEFF00) begin
      miscompares++;
      $display("[TB] FAIL wrap_read_addrs: got %h expected feff00",
               {lgAddr[1], lgAddr[4], lgAddr[7]});
    end
    vectors++;
    if (bus.op_a !== aW || bus.op_b !== bW) begin
      miscompares++;
      $display("[TB] FAIL wrap_operands: got a=%h b=%h", bus.op_a, bus.op_b);
    end
    vectors++;
    if (wrAddr !== 8'h01 || firstDone !== expDoneEdge(3) || lgErr[1] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wrap_write: got addr %h done %0d err %b expected 01 %0d 0",
               wrAddr, firstDone, lgErr[1], expDoneEdge(3));
    end
  endtask

  task automatic test_ignored_inputs();
    logic [DATA_W-1:0] hdrW;
    logic [ADDR_W-1:0] base, expAddr;
    base = 8'h80 + 8'($urandom_range(0, 63));
    expAddr = base + 8'd3;
    hdrW = rand256(); hdrW[5:0] = {3'd2, 3'd5};
    applyOp(base, hdrW, rand256(), rand256(), rand256(), 4, 5, 22);
    vectors++;
    if (doneCnt !== 1 || wrenCnt !== 1 || startCnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL ignored_counts: got done %0d wren %0d start %0d expected 1 1 1",
               doneCnt, wrenCnt, startCnt);
    end
    vectors++;
    if (wrAddr !== expAddr || firstDone !== expDoneEdge(4) || lgBusy[WIN] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignored_write: got addr %h done %0d busy %b expected %h %0d 0",
               wrAddr, firstDone, lgBusy[WIN], expAddr, expDoneEdge(4));
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [DATA_W-1:0] hdrW, aW, bW, resW;
      logic [ADDR_W-1:0] base, expAddr;
      logic [2:0]        size, code;
      logic              ok;
      int                k;
      base = 8'($urandom);
      expAddr = base + 8'd3;
      if ($urandom_range(0, 3) != 0) begin
        size = 3'($urandom_range(2, 5));
        code = 3'($urandom_range(0, 3));
      end else begin
        size = 3'($urandom);
        code = 3'($urandom);
      end
      ok = refValid(size, code);
      k = $urandom_range(1, 6);
      hdrW = rand256(); hdrW[5:0] = {code, size};
      aW = rand256(); bW = rand256(); resW = rand256();
      applyOp(base, hdrW, aW, bW, resW, k, 0, 0);
      vectors++;
      if (ok) begin
        if (firstDone !== expDoneEdge(k) || doneCnt !== 1 || wrAddr !== expAddr ||
            wrData !== resW || bus.op_a !== aW || bus.op_b !== bW) begin
          miscompares++;
          $display("[TB] FAIL random_op%0d: got done %0d x%0d addr %h expected done %0d x1 addr %h",
                   it, firstDone, doneCnt, wrAddr, expDoneEdge(k), expAddr);
        end
      end else begin
        if (firstErr !== expHdrErrEdge() || wrenCnt !== 0 || doneCnt !== 0) begin
          miscompares++;
          $display("[TB] FAIL random_bad%0d: got err %0d wren %0d done %0d expected %0d 0 0",
                   it, firstErr, wrenCnt, doneCnt, expHdrErrEdge());
        end
      end
    end
  endtask

  task automatic test_reset_exec();
    logic [DATA_W-1:0] hdrW, resW;
    int wrenSeen;
    hdrW = rand256(); hdrW[5:0] = 6'h03;
    @(negedge clk);
    mem[8'h20] = hdrW;
    mem[8'h21] = rand256();
    mem[8'h22] = rand256();
    kTarget  = 0;
    start    = 1'b1;
    baseAddr = 8'h20;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, error, bus.ram_wren, bus.op_start} !== 5'b0 ||
        {bus.ram_addr, bus.op_size, bus.op_code} !== 14'h0) begin
      miscompares++;
      $display("[TB] FAIL rst_exec_ctrl: got flags %b addr %h", {busy, done, error,
               bus.ram_wren, bus.op_start}, bus.ram_addr);
    end
    vectors++;
    if ((bus.ram_wdata | bus.op_a | bus.op_b) !== '0) begin
      miscompares++;
      $display("[TB] FAIL rst_exec_data: got %h expected 0", bus.ram_wdata | bus.op_a | bus.op_b);
    end
    wrenSeen = 0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
      if (bus.ram_wren) wrenSeen++;
    end
    vectors++;
    if (wrenSeen !== 0) begin
      miscompares++;
      $display("[TB] FAIL rst_exec_no_write: got %0d expected 0", wrenSeen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    resW = rand256();
    applyOp(8'h30, hdrW, rand256(), rand256(), resW, 2, 0, 0);
    vectors++;
    if (firstDone !== expDoneEdge(2) || wrAddr !== 8'h33 || wrData !== resW) begin
      miscompares++;
      $display("[TB] FAIL rst_exec_restart: got done %0d addr %h expected %0d 33",
               firstDone, wrAddr, expDoneEdge(2));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = rand256();
    test_reset();
    test_nominal();
    test_invalid_header();
    test_timeout();
    test_wrap();
    test_ignored_inputs();
    test_random();
    test_reset_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
